// File: rtl/acoustics_uart_pkg.sv
// Shared constants and types for the UART response path.
// Frame lengths exist for both builds; the active pair is selected by the
// UART_FRAME_CHECKSUM_EN macro through last_index().
package acoustics_uart_pkg;

    localparam logic [7:0] OP_CH1 = 8'h01;
    localparam logic [7:0] OP_CH2 = 8'h02;
    localparam logic [7:0] OP_CH3 = 8'h03;
    localparam logic [7:0] OP_CH4 = 8'h04;
    localparam logic [7:0] OP_ALL = 8'h0F;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam logic [3:0] FRAME_LEN_SINGLE      = 4'd4;
    localparam logic [3:0] FRAME_LEN_ALL         = 4'd10;
    localparam logic [3:0] FRAME_LEN_SINGLE_CSUM = 4'd5;
    localparam logic [3:0] FRAME_LEN_ALL_CSUM    = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } framer_state_t;

    // Index of the final byte of a frame in the active build.
    function automatic logic [3:0] last_index(input logic is_all);
`ifdef UART_FRAME_CHECKSUM_EN
        return is_all ? (FRAME_LEN_ALL_CSUM - 4'd1) : (FRAME_LEN_SINGLE_CSUM - 4'd1);
`else
        return is_all ? (FRAME_LEN_ALL - 4'd1) : (FRAME_LEN_SINGLE - 4'd1);
`endif
    endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational selection of the frame byte at a given index.
// Layout: header, opcode, then {hi, lo} pairs (hi = {6'b0, val[9:8]}).
// With UART_FRAME_CHECKSUM_EN defined, the last index carries the checksum.
module frame_byte_sel
    import acoustics_uart_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_DEFAULT
) (
    input  logic [39:0] snap,
    input  logic [7:0]  op,
    input  logic        is_all,
    input  logic [3:0]  cnt,
`ifdef UART_FRAME_CHECKSUM_EN
    input  logic [7:0]  csum,
`endif
    output logic [7:0]  byte_out
);

    logic [9:0] ch_val [4];
    logic [1:0] pair;
    logic [1:0] sel_ch;
    logic [9:0] sel_val;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        assign ch_val[gi] = snap[gi*10 +: 10];
    end

    // Map the byte index to a channel value and pick the hi or lo half.
    always_comb begin
        pair = 2'd3;
        case (cnt)
            4'd2, 4'd3: pair = 2'd0;
            4'd4, 4'd5: pair = 2'd1;
            4'd6, 4'd7: pair = 2'd2;
            default:    pair = 2'd3;
        endcase
        // Single-channel opcodes 1..4 map to channel index 0..3 via low bits.
        sel_ch  = is_all ? pair : (op[1:0] - 2'd1);
        sel_val = ch_val[sel_ch];

        if (cnt == 4'd0)
            byte_out = HEADER_BYTE;
        else if (cnt == 4'd1)
            byte_out = op;
`ifdef UART_FRAME_CHECKSUM_EN
        else if (cnt == last_index(is_all))
            byte_out = csum;
`endif
        else if (!cnt[0])
            byte_out = {6'b0, sel_val[9:8]};
        else
            byte_out = sel_val[7:0];
    end

endmodule

// File: rtl/uart_response_framer.sv
// Opcode-driven response framer feeding the UART TX byte handshake.
// Snapshots ch_max and the opcode on accept, then streams the frame.
// Optional trailing checksum byte: define UART_FRAME_CHECKSUM_EN.
module uart_response_framer
    import acoustics_uart_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_DEFAULT,
    parameter logic [7:0] ALL_OPCODE  = OP_ALL
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_byte,
    input  logic [39:0] ch_max,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_write_en,
    output logic        busy,
    output logic        frame_done,
    output logic        cmd_error,
    output logic        cmd_overrun
);

    framer_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [39:0]   snap_q, snap_d;
    logic [7:0]    op_q, op_d;
    logic          is_all_q, is_all_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic [7:0] cur_byte;
    logic       cmd_is_all;
    logic       cmd_known;
    logic       xfer;

    assign cmd_is_all = (cmd_byte == ALL_OPCODE);
    assign cmd_known  = cmd_is_all || ((cmd_byte >= OP_CH1) && (cmd_byte <= OP_CH4));
    assign xfer       = (state_q == SEND) && tx_ready;

    frame_byte_sel #(
        .HEADER_BYTE (HEADER_BYTE)
    ) u_byte_sel (
        .snap     (snap_q),
        .op       (op_q),
        .is_all   (is_all_q),
        .cnt      (cnt_q),
`ifdef UART_FRAME_CHECKSUM_EN
        .csum     (csum_q),
`endif
        .byte_out (cur_byte)
    );

    // Outputs decode straight from state so reset clears them asynchronously.
    assign tx_write_en = (state_q == SEND);
    assign busy        = (state_q == SEND);
    assign frame_done  = (state_q == DONE);
    assign tx_data     = (state_q == SEND) ? cur_byte : 8'h00;
    assign cmd_error   = err_q;
    assign cmd_overrun = ovr_q;

    // Next-state: accept/reject commands, advance on each handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        op_d     = op_q;
        is_all_d = is_all_q;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_known) begin
                        state_d  = SEND;
                        cnt_d    = 4'd0;
                        snap_d   = ch_max;
                        op_d     = cmd_byte;
                        is_all_d = cmd_is_all;
`ifdef UART_FRAME_CHECKSUM_EN
                        csum_d   = 8'h00;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                // No queueing: a command during a frame is reported and dropped.
                ovr_d = cmd_valid;
                if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                    // Header is excluded; adding the checksum byte itself is harmless.
                    if (cnt_q != 4'd0)
                        csum_d = csum_q + cur_byte;
`endif
                    if (cnt_q == last_index(is_all_q))
                        state_d = DONE;
                end
            end
            DONE: begin
                ovr_d   = cmd_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            snap_q   <= 40'd0;
            op_q     <= 8'h00;
            is_all_q <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            op_q     <= op_d;
            is_all_q <= is_all_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_response_framer.sv
// Scoreboard bench for uart_response_framer: the driver pushes expected
// bytes, a negedge monitor pops and compares on every handshake.
module tb_uart_response_framer;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_byte = 8'h00;
    logic [39:0] ch_max = 40'd0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_write_en;
    logic        busy;
    logic        frame_done;
    logic        cmd_error;
    logic        cmd_overrun;

    always #5 clk = ~clk;

    uart_response_framer dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .ch_max      (ch_max),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_write_en (tx_write_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .cmd_error   (cmd_error),
        .cmd_overrun (cmd_overrun)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected-frame builders; checksum byte appended only in that build.
    task automatic push_frame(input logic [7:0] b[$]);
        logic [7:0] sum = 8'h00;
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            if (i != 0) sum += b[i];
        end
        if (CS == 1) exp_q.push_back(sum);
    endtask

    task automatic push_single(input logic [7:0] op, input logic [9:0] v);
        logic [7:0] b[$];
        b = '{8'hA5, op, {6'b0, v[9:8]}, v[7:0]};
        push_frame(b);
    endtask

    task automatic push_all(input logic [39:0] m);
        logic [7:0] b[$];
        b = '{8'hA5, 8'h0F};
        for (int c = 0; c < 4; c++) begin
            logic [9:0] v;
            v = m[c*10 +: 10];
            b.push_back({6'b0, v[9:8]});
            b.push_back(v[7:0]);
        end
        push_frame(b);
    endtask

    task automatic send_cmd(input logic [7:0] op);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_byte  = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for frame_done; exp_cycles 0 skips the latency check.
    task automatic wait_done(input int exp_cycles);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!frame_done && c < 200);
        if (!frame_done) check("frame_done_timeout", 32'd0, 32'd1);
        else if (exp_cycles > 0) check("frame_cycles", c, exp_cycles);
    endtask

    // Monitor: byte compare on handshake, stall stability, post-frame status.
    logic       final_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (final_prev)
            check("done_status", {29'd0, frame_done, tx_write_en, busy}, 32'b100);
        final_prev = 1'b0;
        if (stall_prev && tx_write_en)
            check("stall_hold", tx_data, stall_data);
        stall_prev = 1'b0;
        if (tx_write_en && tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %0h, required no byte", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
                if (exp_q.size() == 0) final_prev = 1'b1;
            end
        end else if (tx_write_en) begin
            stall_prev = 1'b1;
            stall_data = tx_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("reset_outputs", {18'd0, tx_data, tx_write_en, busy, frame_done, cmd_error, cmd_overrun, 1'b0},
              32'd0);
        reset_b  = 1'b1;
        tx_ready = 1'b1;

        // Single channel 2: A5 02 03 A7 (+AC)
        ch_max = {10'h0AA, 10'h111, 10'h3A7, 10'h05C};
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
        exp_q.push_back(8'h03); exp_q.push_back(8'hA7);
        if (CS == 1) exp_q.push_back(8'hAC);
        send_cmd(8'h02);
        check("accept_busy", {30'd0, busy, tx_write_en}, 32'b11);
        wait_done(5 + CS);

        // All channels: A5 0F 00 01 02 00 03 FF 01 55 (+6A)
        ch_max = {10'h155, 10'h3FF, 10'h200, 10'h001};
        begin
            logic [7:0] b[$];
            b = '{8'hA5, 8'h0F, 8'h00, 8'h01, 8'h02, 8'h00, 8'h03, 8'hFF, 8'h01, 8'h55};
            foreach (b[i]) exp_q.push_back(b[i]);
            if (CS == 1) exp_q.push_back(8'h6A);
        end
        send_cmd(8'h0F);
        wait_done(11 + CS);

        // Stalls: tx_ready 1,0,0,1 - channel 3 = 1E4 -> A5 03 01 E4 (+E8)
        ch_max = {10'h000, 10'h1E4, 10'h000, 10'h000};
        push_single(8'h03, 10'h1E4);
        send_cmd(8'h03);
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_done(0);

        // Unknown opcode
        send_cmd(8'h07);
        @(negedge clk);
        check("err_pulse", {29'd0, cmd_error, tx_write_en, busy}, 32'b100);
        @(negedge clk);
        check("err_clear", {30'd0, cmd_error, tx_write_en}, 32'b00);

        // Overrun while busy: channel 1 frame must complete unchanged
        ch_max = {10'h2C3, 10'h000, 10'h000, 10'h0AB};
        push_single(8'h01, 10'h0AB);
        send_cmd(8'h01);
        send_cmd(8'h04);
        @(negedge clk);
        check("overrun_pulse", {31'd0, cmd_overrun}, 32'd1);
        @(negedge clk);
        check("overrun_clear", {31'd0, cmd_overrun}, 32'd0);
        wait_done(0);
        repeat (3) @(negedge clk);
        check("idle_after_overrun", {30'd0, tx_write_en, busy}, 32'd0);

        // Snapshot: ch_max changes right after accept
        ch_max = {10'h155, 10'h3FF, 10'h200, 10'h001};
        push_all(ch_max);
        send_cmd(8'h0F);
        ch_max = {10'h2AA, 10'h0F0, 10'h1C3, 10'h333};
        wait_done(11 + CS);

        // Reset after the third byte
        ch_max = {10'h2C3, 10'h000, 10'h000, 10'h000};
        push_single(8'h04, 10'h2C3);
        send_cmd(8'h04);
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b0;
        #1 check("async_reset", {21'd0, tx_data, tx_write_en, busy, frame_done}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        ch_max = {10'h000, 10'h000, 10'h000, 10'h0AB};
        push_single(8'h01, 10'h0AB);
        send_cmd(8'h01);
        wait_done(5 + CS);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
